// File: rtl/db_arbiter.sv
// -----------------------------------------------------------------------------
// db_arbiter
//   Two-master round-robin arbiter for the shared memory data bus.
//   Master 0 is the CPU core bus port; master 1 is a secondary requester
//   (DMA / TLB refill walker). The grant is held until the slave signals
//   ready, the granted master aborts, or (optionally) the watchdog expires.
//
//   Optional feature: define DB_ARB_TIMEOUT_EN to build in the BUSY watchdog
//   (TIMEOUT_CYCLES stalled cycles force completion with all-ones data and a
//   one-cycle bus_error pulse). Without it, bus_error is tied low.
//
// Ports
//   clk, res                  clock (rising edge), async active-low reset
//   m0_* / m1_*               master request (addr, accessType, dataOut) and
//                             per-master ready completion strobe
//   m_dataIn                  read data broadcast to both masters
//   s_*                       single downstream slave port
//   grant, busy               granted master index (valid while busy) and
//                             transaction-in-progress flag
//   bus_error                 one-cycle watchdog timeout pulse
// -----------------------------------------------------------------------------
module db_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_accessType,
  input  logic [DATA_W-1:0] m0_dataOut,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_accessType,
  input  logic [DATA_W-1:0] m1_dataOut,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m_dataIn,
  output logic [ADDR_W-1:0] s_addr,
  output logic [1:0]        s_accessType,
  output logic [DATA_W-1:0] s_dataOut,
  input  logic [DATA_W-1:0] s_dataIn,
  input  logic              s_ready,
  output logic              grant,
  output logic              busy,
  output logic              bus_error
);

  localparam logic [1:0] MEM_ACCESS_NONE = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_grant;
  logic   w_grant_nxt;
  logic   r_last_grant;
  logic   w_last_grant_nxt;

  logic   w_req0;
  logic   w_req1;
  logic   w_gnt_req;
  logic   w_busy;
  logic   w_timeout;

  assign w_req0    = (m0_accessType != MEM_ACCESS_NONE);
  assign w_req1    = (m1_accessType != MEM_ACCESS_NONE);
  assign w_busy    = (r_state == ST_BUSY);
  assign w_gnt_req = r_grant ? w_req1 : w_req0;

`ifdef DB_ARB_TIMEOUT_EN
  // Counts stalled BUSY cycles already elapsed; reads 0 on the first BUSY
  // cycle, so the watchdog fires on the TIMEOUT_CYCLES-th stalled cycle.
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_to_cnt <= '0;
    end else if (!w_busy) begin
      r_to_cnt <= '0;
    end else if (!s_ready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // A real s_ready in the same cycle wins: normal completion, no error.
  assign w_timeout = w_busy && !s_ready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog not built; its parameters are referenced only to keep the
  // parameter list identical between both builds.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0) && (TO_W > 0);
`endif

  // State, grant and round-robin history registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;   // master 0 wins the first tie
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    if (r_state == ST_IDLE) begin
      if (w_req0 || w_req1) begin
        w_state_nxt = ST_BUSY;
        // Tie goes to the master that did not own the last transaction;
        // otherwise the sole requester (req1 set means master 1).
        w_grant_nxt = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
      end
    end else begin
      // Completion, watchdog expiry or abort by the granted master all
      // return to IDLE, which guarantees a NONE cycle on the slave.
      if (s_ready || w_timeout || !w_gnt_req) begin
        w_state_nxt      = ST_IDLE;
        w_last_grant_nxt = r_grant;
      end
    end
  end

  // Slave-side mux and ready routing. The ready paths use only registered
  // state/grant plus s_ready, never a master's accessType, so the CPU's
  // ready -> nextState -> accessType path cannot close a combinational loop.
  always_comb begin
    s_accessType = MEM_ACCESS_NONE;
    s_addr       = '0;
    s_dataOut    = '0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    if (w_busy) begin
      if (r_grant) begin
        s_accessType = m1_accessType;
        s_addr       = m1_addr;
        s_dataOut    = m1_dataOut;
        m1_ready     = s_ready || w_timeout;
      end else begin
        s_accessType = m0_accessType;
        s_addr       = m0_addr;
        s_dataOut    = m0_dataOut;
        m0_ready     = s_ready || w_timeout;
      end
    end
  end

  assign m_dataIn  = w_timeout ? {DATA_W{1'b1}} : s_dataIn;
  assign grant     = r_grant;
  assign busy      = w_busy;
  assign bus_error = w_timeout;

endmodule
